// File: rtl/seg_pkg.sv
// Shared widths and 7-segment glyph table for the BCD counter display.
package seg_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    // Active-high glyphs, bit0 = segment A .. bit6 = segment G.
    localparam logic [SEG_W-1:0] SEG_PATTERN [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to 7-segment pattern; non-BCD codes and forced blank render dark.
module seven_seg_decoder
    import seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [BCD_W-1:0] bcd,
    input  logic             blank,
    output logic [SEG_W-1:0] seg_c
);

    logic [SEG_W-1:0] lit;

    always_comb begin
        lit = SEG_BLANK;
        if (!blank && (bcd <= 4'd9)) begin
            lit = SEG_PATTERN[bcd];
        end
        seg_c = SEG_ACTIVE_LOW ? ~lit : lit;
    end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with clear, checked parallel load and 7-segment outputs.
// Optional build macro LEADING_ZERO_BLANK_EN darkens zero digits above the highest non-zero digit.
module bcd_counter_display
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SATURATE       = 1'b0
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    input  logic                        i_Inc,
    input  logic                        i_Dec,
    input  logic                        i_Clear,
    input  logic                        i_Load,
    input  logic [BCD_W*NUM_DIGITS-1:0] i_Load_Value,
    output logic [BCD_W*NUM_DIGITS-1:0] o_Count,
    output logic [SEG_W*NUM_DIGITS-1:0] o_Segments,
    output logic                        o_Limit,
    output logic                        o_Load_Err
);

    localparam int unsigned CNT_W  = BCD_W * NUM_DIGITS;
    localparam int unsigned SEGS_W = SEG_W * NUM_DIGITS;

    logic              inc_prev, dec_prev;
    logic              inc_rise, dec_rise;
    logic [CNT_W-1:0]  up_val, dn_val, count_d;
    logic              up_wrap, dn_wrap, load_ok;
    logic              limit_d, load_err_d;
    logic [NUM_DIGITS-1:0] blank_c;
    logic [SEGS_W-1:0] seg_c;

    assign inc_rise = i_Inc & ~inc_prev;
    assign dec_rise = i_Dec & ~dec_prev;

    // Ripple increment/decrement candidates; wrap flags mean every digit carried/borrowed.
    always_comb begin
        up_val  = o_Count;
        dn_val  = o_Count;
        up_wrap = 1'b1;
        dn_wrap = 1'b1;
        load_ok = 1'b1;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (up_wrap) begin
                if (o_Count[k*BCD_W +: BCD_W] == 4'd9) begin
                    up_val[k*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    up_val[k*BCD_W +: BCD_W] = o_Count[k*BCD_W +: BCD_W] + 4'd1;
                    up_wrap = 1'b0;
                end
            end
            if (dn_wrap) begin
                if (o_Count[k*BCD_W +: BCD_W] == 4'd0) begin
                    dn_val[k*BCD_W +: BCD_W] = 4'd9;
                end else begin
                    dn_val[k*BCD_W +: BCD_W] = o_Count[k*BCD_W +: BCD_W] - 4'd1;
                    dn_wrap = 1'b0;
                end
            end
            if (i_Load_Value[k*BCD_W +: BCD_W] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    // Clear beats load, load beats counting; simultaneous inc/dec edges cancel.
    always_comb begin
        count_d    = o_Count;
        limit_d    = 1'b0;
        load_err_d = 1'b0;
        if (i_Clear) begin
            count_d = '0;
        end else if (i_Load) begin
            if (load_ok) begin
                count_d = i_Load_Value;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (inc_rise && !dec_rise) begin
            limit_d = up_wrap;
            if (!(up_wrap && SATURATE)) begin
                count_d = up_val;
            end
        end else if (dec_rise && !inc_rise) begin
            limit_d = dn_wrap;
            if (!(dn_wrap && SATURATE)) begin
                count_d = dn_val;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; digit 0 is never blanked.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        blank_c = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            if (o_Count[k*BCD_W +: BCD_W] != 4'd0) begin
                seen = 1'b1;
            end
            blank_c[k] = ~seen;
        end
    end
`else
    assign blank_c = '0;
`endif

    for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_digit
        seven_seg_decoder #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_dec (
            .bcd   (o_Count[g*BCD_W +: BCD_W]),
            .blank (blank_c[g]),
            .seg_c (seg_c[g*SEG_W +: SEG_W])
        );
    end

    // History resets high so a button held through reset is not seen as an edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            inc_prev   <= 1'b1;
            dec_prev   <= 1'b1;
            o_Count    <= '0;
            o_Limit    <= 1'b0;
            o_Load_Err <= 1'b0;
            o_Segments <= {SEGS_W{SEG_ACTIVE_LOW}};
        end else begin
            inc_prev   <= i_Inc;
            dec_prev   <= i_Dec;
            o_Count    <= count_d;
            o_Limit    <= limit_d;
            o_Load_Err <= load_err_d;
            o_Segments <= seg_c;
        end
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench for bcd_counter_display: wrap and saturate instances against an integer-valued model.
module tb_bcd_counter_display;

    localparam int ND = 2;
    localparam int MAXV = 99;

    logic        clk, rst_n;
    logic        inc, dec, clr, load;
    logic [7:0]  load_val;
    logic [7:0]  cnt_w, cnt_s;
    logic [13:0] seg_w, seg_s;
    logic        lim_w, lim_s, err_w, err_s;

    int checks   = 0;
    int failures = 0;

    bcd_counter_display #(.NUM_DIGITS(ND), .SEG_ACTIVE_LOW(1'b1), .SATURATE(1'b0)) dut_wrap (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Inc(inc), .i_Dec(dec), .i_Clear(clr),
        .i_Load(load), .i_Load_Value(load_val), .o_Count(cnt_w), .o_Segments(seg_w),
        .o_Limit(lim_w), .o_Load_Err(err_w)
    );

    bcd_counter_display #(.NUM_DIGITS(ND), .SEG_ACTIVE_LOW(1'b1), .SATURATE(1'b1)) dut_sat (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Inc(inc), .i_Dec(dec), .i_Clear(clr),
        .i_Load(load), .i_Load_Value(load_val), .o_Count(cnt_s), .o_Segments(seg_s),
        .o_Limit(lim_s), .o_Load_Err(err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        from_bcd = int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Display image of an integer value, active-low, leading-zero rule applied when built in.
    function automatic logic [13:0] exp_seg(input int v, input bit dark);
        logic [6:0] glyph [0:9];
        logic [6:0] lit;
        logic [13:0] r;
        int p;
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        r = '0;
        p = 1;
        for (int k = 0; k < ND; k++) begin
            lit = glyph[(v / p) % 10];
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && v < p) lit = 7'h00;
`endif
            if (dark) lit = 7'h00;
            r[k*7 +: 7] = ~lit;
            p = p * 10;
        end
        return r;
    endfunction

    // Model: index 0 wraps, index 1 saturates.
    int m_val [2];
    int m_sval [2];
    bit m_lim [2];
    bit m_err [2];
    bit m_dark, m_ip, m_dp;

    always @(posedge clk or negedge rst_n) begin
        bit ir, dr;
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                m_val[s] <= 0; m_sval[s] <= 0; m_lim[s] <= 0; m_err[s] <= 0;
            end
            m_dark <= 1; m_ip <= 1; m_dp <= 1;
        end else begin
            ir = inc && !m_ip;
            dr = dec && !m_dp;
            m_ip   <= inc;
            m_dp   <= dec;
            m_dark <= 0;
            for (int s = 0; s < 2; s++) begin
                m_sval[s] <= m_val[s];
                m_lim[s]  <= 0;
                m_err[s]  <= 0;
                if (clr) begin
                    m_val[s] <= 0;
                end else if (load) begin
                    if (load_val[7:4] <= 4'd9 && load_val[3:0] <= 4'd9) m_val[s] <= from_bcd(load_val);
                    else m_err[s] <= 1;
                end else if (ir && !dr) begin
                    if (m_val[s] == MAXV) begin
                        m_lim[s] <= 1;
                        if (s == 0) m_val[s] <= 0;
                    end else m_val[s] <= m_val[s] + 1;
                end else if (dr && !ir) begin
                    if (m_val[s] == 0) begin
                        m_lim[s] <= 1;
                        if (s == 0) m_val[s] <= MAXV;
                    end else m_val[s] <= m_val[s] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cnt_wrap", 32'(cnt_w), 32'(to_bcd(m_val[0])));
        check("seg_wrap", 32'(seg_w), 32'(exp_seg(m_sval[0], m_dark)));
        check("lim_wrap", 32'(lim_w), 32'(m_lim[0]));
        check("err_wrap", 32'(err_w), 32'(m_err[0]));
        check("cnt_sat",  32'(cnt_s), 32'(to_bcd(m_val[1])));
        check("seg_sat",  32'(seg_s), 32'(exp_seg(m_sval[1], m_dark)));
        check("lim_sat",  32'(lim_s), 32'(m_lim[1]));
        check("err_sat",  32'(err_s), 32'(m_err[1]));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        logic [13:0] s_exp;
        logic [6:0]  d1_exp;
        rst_n = 1'b0; inc = 0; dec = 0; clr = 0; load = 0; load_val = '0;
        tick(); tick();
        check("rst_cnt", 32'(cnt_w), 32'h00);
        check("rst_seg", 32'(seg_w), 32'h3FFF);
        check("rst_lim", 32'(lim_w), 32'h0);
        rst_n = 1'b1;
        tick();

        // Ten up-pulses reach 10
        repeat (10) begin
            inc = 1; tick(); inc = 0; tick();
        end
        tick();
        s_exp = {~7'h06, ~7'h3F};
        check("t1_cnt", 32'(cnt_w), 32'h10);
        check("t1_seg", 32'(seg_w), 32'(s_exp));

        // Overflow from 99
        do_load(8'h99); tick();
        inc = 1; tick();
        check("t2_cnt_wrap", 32'(cnt_w), 32'h00);
        check("t2_lim_wrap", 32'(lim_w), 32'h1);
        check("t2_cnt_sat",  32'(cnt_s), 32'h99);
        check("t2_lim_sat",  32'(lim_s), 32'h1);
        inc = 0; tick();
        check("t2_lim_once", 32'(lim_w), 32'h0);

        // Underflow from 00, then borrow across digits
        do_load(8'h00); tick();
        dec = 1; tick();
        check("t3_cnt_wrap", 32'(cnt_w), 32'h99);
        check("t3_lim_wrap", 32'(lim_w), 32'h1);
        check("t3_cnt_sat",  32'(cnt_s), 32'h00);
        dec = 0; tick();
        do_load(8'h40); tick();
        dec = 1; tick();
        check("t3_borrow", 32'(cnt_w), 32'h39);
        dec = 0; tick();

        // Bad load rejected; clear beats load
        do_load(8'h3A);
        check("t4_cnt", 32'(cnt_w), 32'h39);
        check("t4_err", 32'(err_w), 32'h1);
        tick();
        check("t4_err_once", 32'(err_w), 32'h0);
        clr = 1; load = 1; load_val = 8'h55; tick();
        clr = 0; load = 0;
        check("t4_clr_cnt", 32'(cnt_w), 32'h00);
        check("t4_clr_err", 32'(err_w), 32'h0);
        tick();

        // Simultaneous edges cancel; held inc counts once
        inc = 1; dec = 1; tick();
        check("t5_both", 32'(cnt_w), 32'h00);
        check("t5_both_lim", 32'(lim_w), 32'h0);
        inc = 0; dec = 0; tick();
        inc = 1;
        repeat (100) tick();
        check("t5_held", 32'(cnt_w), 32'h01);
        inc = 0; tick();

        // Edge during clear is consumed
        clr = 1; inc = 1; tick();
        clr = 0; tick();
        check("t5_clr_edge", 32'(cnt_w), 32'h00);
        inc = 0; tick();

        // Reset mid-count with inc held through deassert
        do_load(8'h57);
        inc = 1; tick();
        check("t6_pre", 32'(cnt_w), 32'h58);
        rst_n = 0; #1;
        check("t6_rst_cnt", 32'(cnt_w), 32'h00);
        check("t6_rst_seg", 32'(seg_w), 32'h3FFF);
        tick(); tick();
        rst_n = 1;
        repeat (3) tick();
        check("t6_no_count", 32'(cnt_w), 32'h00);
        inc = 0; tick();

        // Leading-zero display at 05
        do_load(8'h05); tick(); tick();
`ifdef LEADING_ZERO_BLANK_EN
        d1_exp = 7'h7F;
`else
        d1_exp = ~7'h3F;
`endif
        check("t6_digit1", 32'(seg_w[13:7]), 32'(d1_exp));
        check("t6_digit0", 32'(seg_w[6:0]), 32'h12);

        // A few mixed steps for the model
        dec = 1; tick(); dec = 0; tick();
        inc = 1; tick(); inc = 0; tick();
        do_load(8'h09); inc = 1; tick(); inc = 0; tick();
        check("carry_09", 32'(cnt_w), 32'h10);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
